hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for the five-stage pipelined CPU.
// Compares the D-stage operand reads (Tuse) against pending writes in E and M
// (Tnew), and produces:
//   - freeze enables for the PC and the F/D register,
//   - the bubble request that clears the D/E register,
//   - forwarding-mux selects for the D and E stages.
// Also holds the mult/div busy counter, which stalls HI/LO users while a
// mult/div is in flight.
//
// Ports
//   i_clk            pipeline clock, rising edge
//   i_reset          asynchronous, active-low; clears the busy counter
//   i_rs_D, i_rt_D   D-stage source register addresses
//   i_Tuse_rs/rt     cycles until D needs rs/rt (3 = operand unused)
//   i_A1_E, i_A2_E   rs/rt of the E-stage instruction
//   i_A3_E/M/W       destination register of E/M/W
//   i_RegWrite_E/M/W stage writes the register file
//   i_Tnew_E/M       cycles until the stage result is ready (0 = ready)
//   i_md_start_E     E holds mult/multu/div/divu
//   i_md_is_div_E    qualifies i_md_start_E: 1 = div/divu
//   i_md_use_D       D holds mult/div/mfhi/mflo/mthi/mtlo
//   o_PC_en, o_FD_en PC / F/D register write enables
//   o_DE_flush       bubble into the D/E register
//   o_busy           mult/div unit busy
//   o_FwdRS_D/RT_D   D forward select: 0 = RF, 1 = M result, 2 = E result
//   o_FwdA_E/B_E     E forward select: 0 = pipe reg, 1 = W result, 2 = M result
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [4:0] i_rs_D,
   input  logic [4:0] i_rt_D,
   input  logic [1:0] i_Tuse_rs,
   input  logic [1:0] i_Tuse_rt,
   input  logic [4:0] i_A1_E,
   input  logic [4:0] i_A2_E,
   input  logic [4:0] i_A3_E,
   input  logic [4:0] i_A3_M,
   input  logic [4:0] i_A3_W,
   input  logic       i_RegWrite_E,
   input  logic       i_RegWrite_M,
   input  logic       i_RegWrite_W,
   input  logic [1:0] i_Tnew_E,
   input  logic [1:0] i_Tnew_M,
   input  logic       i_md_start_E,
   input  logic       i_md_is_div_E,
   input  logic       i_md_use_D,
   output logic       o_PC_en,
   output logic       o_FD_en,
   output logic       o_DE_flush,
   output logic       o_busy,
   output logic [1:0] o_FwdRS_D,
   output logic [1:0] o_FwdRT_D,
   output logic [1:0] o_FwdA_E,
   output logic [1:0] o_FwdB_E
);

   // Counter must hold the longer of the two latencies; never narrower than 4.
   localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CntWRaw   = $clog2(MaxCycles + 1);
   localparam int unsigned CntW      = (CntWRaw < 4) ? 4 : CntWRaw;

   localparam logic [1:0] TuseNone = 2'd3;

   // Operand read in D collides with a result that will not be ready in time.
   function automatic logic f_hit(input logic [4:0] rd, input logic [1:0] tuse,
                                  input logic [4:0] a3, input logic rw,
                                  input logic [1:0] tnew);
      return (tuse != TuseNone) && (rd != 5'd0) && (rd == a3) && rw && (tnew > tuse);
   endfunction

   // D-stage select: E result wins over M result when both are ready.
   function automatic logic [1:0] f_fwd_d(input logic [4:0] rd);
      logic [1:0] sel;
      sel = 2'd0;
      if (rd != 5'd0) begin
         if ((rd == i_A3_E) && i_RegWrite_E && (i_Tnew_E == 2'd0)) begin
            sel = 2'd2;
         end else if ((rd == i_A3_M) && i_RegWrite_M && (i_Tnew_M == 2'd0)) begin
            sel = 2'd1;
         end
      end
      return sel;
   endfunction

   // E-stage select: M result wins over W result.
   function automatic logic [1:0] f_fwd_e(input logic [4:0] ra);
      logic [1:0] sel;
      sel = 2'd0;
      if (ra != 5'd0) begin
         if ((ra == i_A3_M) && i_RegWrite_M && (i_Tnew_M == 2'd0)) begin
            sel = 2'd2;
         end else if ((ra == i_A3_W) && i_RegWrite_W) begin
            sel = 2'd1;
         end
      end
      return sel;
   endfunction

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic            w_busy;
   logic            w_stall_rf;
   logic            w_stall_md;
   logic            w_stall;

   // ---------------------------------------------------------------------------
   // Mult/div busy counter
   // ---------------------------------------------------------------------------
   always_comb begin
      w_cnt_next = r_cnt;
      // A new mult/div in E reloads even while a previous one is still counting.
      if (i_md_start_E) begin
         w_cnt_next = i_md_is_div_E ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end else if (r_cnt != '0) begin
         w_cnt_next = r_cnt - CntW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign w_busy = (r_cnt != '0);

   // ---------------------------------------------------------------------------
   // Stall generation
   // ---------------------------------------------------------------------------
   always_comb begin
      w_stall_rf = f_hit(i_rs_D, i_Tuse_rs, i_A3_E, i_RegWrite_E, i_Tnew_E)
                 | f_hit(i_rs_D, i_Tuse_rs, i_A3_M, i_RegWrite_M, i_Tnew_M)
                 | f_hit(i_rt_D, i_Tuse_rt, i_A3_E, i_RegWrite_E, i_Tnew_E)
                 | f_hit(i_rt_D, i_Tuse_rt, i_A3_M, i_RegWrite_M, i_Tnew_M);
      // md_start_E covers the cycle the mult/div itself sits in E, before busy rises.
      w_stall_md = i_md_use_D & (w_busy | i_md_start_E);
      w_stall    = w_stall_rf | w_stall_md;
   end

   // D/E is never frozen: a stall only holds PC and F/D and injects a bubble.
   assign o_PC_en    = ~w_stall;
   assign o_FD_en    = ~w_stall;
   assign o_DE_flush = w_stall;
   assign o_busy     = w_busy;

   // ---------------------------------------------------------------------------
   // Forwarding selects
   // ---------------------------------------------------------------------------
   assign o_FwdRS_D = f_fwd_d(i_rs_D);
   assign o_FwdRT_D = f_fwd_d(i_rt_D);
   assign o_FwdA_E  = f_fwd_e(i_A1_E);
   assign o_FwdB_E  = f_fwd_e(i_A2_E);

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int MultN = 5;
   localparam int DivN  = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] rs_D, rt_D, A1_E, A2_E, A3_E, A3_M, A3_W;
   logic [1:0] Tuse_rs, Tuse_rt, Tnew_E, Tnew_M;
   logic       RegWrite_E, RegWrite_M, RegWrite_W;
   logic       md_start_E, md_is_div_E, md_use_D;
   logic       PC_en, FD_en, DE_flush, busy;
   logic [1:0] FwdRS_D, FwdRT_D, FwdA_E, FwdB_E;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycle index and the last accepted mult/div start.
   int cyc  = 0;
   int md_t = -100;
   int md_n = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rs_D(rs_D), .i_rt_D(rt_D), .i_Tuse_rs(Tuse_rs), .i_Tuse_rt(Tuse_rt),
      .i_A1_E(A1_E), .i_A2_E(A2_E), .i_A3_E(A3_E), .i_A3_M(A3_M), .i_A3_W(A3_W),
      .i_RegWrite_E(RegWrite_E), .i_RegWrite_M(RegWrite_M), .i_RegWrite_W(RegWrite_W),
      .i_Tnew_E(Tnew_E), .i_Tnew_M(Tnew_M),
      .i_md_start_E(md_start_E), .i_md_is_div_E(md_is_div_E), .i_md_use_D(md_use_D),
      .o_PC_en(PC_en), .o_FD_en(FD_en), .o_DE_flush(DE_flush), .o_busy(busy),
      .o_FwdRS_D(FwdRS_D), .o_FwdRT_D(FwdRT_D), .o_FwdA_E(FwdA_E), .o_FwdB_E(FwdB_E)
   );

   typedef struct packed {
      logic [4:0] rs, rt;
      logic [1:0] tuse_rs, tuse_rt;
      logic [4:0] a1e, a2e, a3e, a3m, a3w;
      logic       rwe, rwm, rww;
      logic [1:0] tnewe, tnewm;
      logic       mds, mddiv, mduse;
   } in_t;

   typedef struct {
      string       name;
      in_t         in;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic in_t idle();
      in_t v;
      v = '0;
      v.tuse_rs = 2'd3;
      v.tuse_rt = 2'd3;
      return v;
   endfunction

   // Expected output word {PC_en, FD_en, DE_flush, busy, FwdRS, FwdRT, FwdA, FwdB}, busy = 0.
   function automatic logic [11:0] ex(logic stall, logic [1:0] frs, logic [1:0] frt,
                                      logic [1:0] fa, logic [1:0] fb);
      return {~stall, ~stall, stall, 1'b0, frs, frt, fa, fb};
   endfunction

   function automatic logic [11:0] dut_out();
      return {PC_en, FD_en, DE_flush, busy, FwdRS_D, FwdRT_D, FwdA_E, FwdB_E};
   endfunction

   task automatic add(string n, in_t v, logic [11:0] e);
      vec_t t;
      t.name = n;
      t.in   = v;
      t.exp  = e;
      tbl.push_back(t);
   endtask

   task automatic drive(in_t v);
      rs_D = v.rs; rt_D = v.rt; Tuse_rs = v.tuse_rs; Tuse_rt = v.tuse_rt;
      A1_E = v.a1e; A2_E = v.a2e; A3_E = v.a3e; A3_M = v.a3m; A3_W = v.a3w;
      RegWrite_E = v.rwe; RegWrite_M = v.rwm; RegWrite_W = v.rww;
      Tnew_E = v.tnewe; Tnew_M = v.tnewm;
      md_start_E = v.mds; md_is_div_E = v.mddiv; md_use_D = v.mduse;
   endtask

   task automatic cmp(string name, logic [11:0] got, logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic cmp1(string name, int k, logic got, logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %b exp %b", name, k, got, exp);
      end
   endtask

   // Advance one clock; the model records a mult/div start accepted at this edge.
   task automatic tick();
      @(posedge clk);
      if (reset && md_start_E) begin
         md_t = cyc;
         md_n = md_is_div_E ? DivN : MultN;
      end
      cyc++;
      #1;
   endtask

   // Busy means the current cycle lies in (start, start + N].
   function automatic logic m_busy();
      return (cyc > md_t) && (cyc <= md_t + md_n);
   endfunction

   function automatic logic m_hit(logic [4:0] rd, logic [1:0] tuse, logic [4:0] a3,
                                  logic rw, logic [1:0] tnew);
      return (tuse != 2'd3) && (rd != 0) && (rd == a3) && rw && (int'(tnew) > int'(tuse));
   endfunction

   function automatic logic [1:0] m_fd(logic [4:0] r);
      if (r == 0) return 2'd0;
      if (r == A3_E && RegWrite_E && Tnew_E == 0) return 2'd2;
      if (r == A3_M && RegWrite_M && Tnew_M == 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [1:0] m_fe(logic [4:0] r);
      if (r == 0) return 2'd0;
      if (r == A3_M && RegWrite_M && Tnew_M == 0) return 2'd2;
      if (r == A3_W && RegWrite_W) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [11:0] m_out();
      logic st;
      logic b;
      b  = m_busy();
      st = m_hit(rs_D, Tuse_rs, A3_E, RegWrite_E, Tnew_E)
         || m_hit(rs_D, Tuse_rs, A3_M, RegWrite_M, Tnew_M)
         || m_hit(rt_D, Tuse_rt, A3_E, RegWrite_E, Tnew_E)
         || m_hit(rt_D, Tuse_rt, A3_M, RegWrite_M, Tnew_M)
         || (md_use_D && (b || md_start_E));
      return {~st, ~st, st, b, m_fd(rs_D), m_fd(rt_D), m_fe(A1_E), m_fe(A2_E)};
   endfunction

   initial begin
      in_t v;

      // ---- reset state ----------------------------------------------------
      drive(idle());
      #2;
      cmp("reset_idle", dut_out(), ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));

      // ---- combinational vectors, applied with the counter held in reset ---
      v = idle(); v.rs = 8; v.tuse_rs = 1; v.a3e = 8; v.rwe = 1; v.tnewe = 2;
      add("lw_in_E", v, ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 8; v.tuse_rs = 1; v.a3m = 8; v.rwm = 1; v.tnewm = 1;
      add("lw_in_M_tnew1", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v.tnewm = 0;
      add("lw_in_M_tnew0", v, ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 9; v.tuse_rs = 0; v.a3e = 9; v.rwe = 1; v.tnewe = 1;
      add("beq_addu_E", v, ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 9; v.tuse_rs = 0; v.a3m = 9; v.rwm = 1; v.tnewm = 0;
      add("beq_addu_M", v, ex(1'b0, 2'd1, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 0; v.tuse_rs = 1; v.a3e = 0; v.rwe = 1; v.tnewe = 2;
      add("addr_zero", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 8; v.tuse_rs = 3; v.a3e = 8; v.rwe = 1; v.tnewe = 2;
      add("tuse_unused", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rt = 5; v.tuse_rt = 0; v.a3m = 5; v.rwm = 1; v.tnewm = 1;
      add("rt_stall_M", v, ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.rs = 4; v.rt = 4; v.tuse_rs = 1; v.a3e = 4; v.rwe = 1; v.a3m = 4; v.rwm = 1;
      add("d_fwd_E_wins", v, ex(1'b0, 2'd2, 2'd2, 2'd0, 2'd0));
      v = idle(); v.rs = 7; v.tuse_rs = 2; v.a3e = 7; v.rwe = 0; v.tnewe = 3;
      add("no_regwrite_E", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.a1e = 6; v.a2e = 6; v.a3m = 6; v.rwm = 1; v.a3w = 6; v.rww = 1;
      add("e_fwd_M_wins", v, ex(1'b0, 2'd0, 2'd0, 2'd2, 2'd2));
      v = idle(); v.a1e = 6; v.a2e = 3; v.a3m = 6; v.rwm = 1; v.tnewm = 1; v.a3w = 6; v.rww = 1;
      add("e_fwd_W", v, ex(1'b0, 2'd0, 2'd0, 2'd1, 2'd0));
      v = idle(); v.a1e = 0; v.a2e = 0; v.a3w = 0; v.rww = 1; v.a3m = 0; v.rwm = 1;
      add("e_fwd_zero", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.mduse = 1;
      add("md_use_idle", v, ex(1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.mduse = 1; v.mds = 1; v.mddiv = 1;
      add("md_use_start", v, ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
      v = idle(); v.mduse = 1; v.mds = 1; v.rs = 8; v.tuse_rs = 0; v.a3e = 8; v.rwe = 1;
      v.tnewe = 1;
      add("rf_and_md_stall", v, ex(1'b1, 2'd0, 2'd0, 2'd0, 2'd0));

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         #2;
         cmp(tbl[i].name, dut_out(), tbl[i].exp);
      end

      // ---- div then mflo: busy cycles 1..10, PC released in 11 -------------
      drive(idle());
      reset = 1'b1;
      tick();
      md_start_E = 1'b1; md_is_div_E = 1'b1;
      #3;
      cmp1("div_busy", 0, busy, 1'b0);
      cmp1("div_pc_en", 0, PC_en, 1'b1);
      tick();
      md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         #3;
         cmp1("div_busy", k, busy, k <= 10);
         cmp1("div_pc_en", k, PC_en, k > 10);
         tick();
      end
      md_use_D = 1'b0;

      // ---- mult reloaded by a second mult in cycle 3 -----------------------
      md_start_E = 1'b1;
      #3;
      cmp1("mult_busy", 0, busy, 1'b0);
      tick();
      for (int k = 1; k <= 9; k++) begin
         md_start_E = (k == 3);
         #3;
         cmp1("mult_busy", k, busy, k <= 8);
         tick();
      end
      md_start_E = 1'b0;

      // ---- reset in cycle 4 of a div --------------------------------------
      md_start_E = 1'b1; md_is_div_E = 1'b1;
      tick();
      md_start_E = 1'b0; md_is_div_E = 1'b0;
      repeat (3) tick();
      #1;
      cmp1("rst_busy_before", 4, busy, 1'b1);
      reset = 1'b0;
      md_t  = -100;
      #1;
      cmp1("rst_busy_async", 4, busy, 1'b0);
      tick();
      reset = 1'b1;
      md_use_D = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         cmp1("rst_after_busy", k, busy, 1'b0);
         cmp1("rst_after_pc_en", k, PC_en, 1'b1);
         tick();
      end
      md_use_D = 1'b0;

      // ---- randomized run against the reference model ----------------------
      for (int n = 0; n < 600; n++) begin
         rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
         A1_E = 5'($urandom_range(0, 3)); A2_E = 5'($urandom_range(0, 3));
         A3_E = 5'($urandom_range(0, 3)); A3_M = 5'($urandom_range(0, 3));
         A3_W = 5'($urandom_range(0, 3));
         Tuse_rs = 2'($urandom_range(0, 3)); Tuse_rt = 2'($urandom_range(0, 3));
         Tnew_E = 2'($urandom_range(0, 2)); Tnew_M = 2'($urandom_range(0, 2));
         RegWrite_E = 1'($urandom_range(0, 1)); RegWrite_M = 1'($urandom_range(0, 1));
         RegWrite_W = 1'($urandom_range(0, 1));
         md_start_E  = ($urandom_range(0, 9) == 0);
         md_is_div_E = 1'($urandom_range(0, 1));
         md_use_D    = ($urandom_range(0, 2) == 0);
         reset       = ($urandom_range(0, 79) != 0);
         if (!reset) md_t = -100;
         #3;
         cmp($sformatf("rand_%0d", n), dut_out(), m_out());
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
